id_ex_stage_reg: RTL and testbench

//  ID/EX pipeline register with load-use hazard detection for the 5-stage MIPS core.

---
 rtl/id_ex_stage_reg.sv | 114 +++++++++++
 tb/tb_id_ex_stage_reg.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//   ID/EX pipeline register for the 5-stage MIPS core, with load-use hazard
//   detection. It captures the decoded operands and control from ID and
//   drives the EX stage. On a load-use hazard, or on a branch flush, it loads
//   a bubble: ex_valid, all control bits and alu_op are zero.
//
// Ports
//   clk, rst_n        rising-edge clock, async active-low reset
//   stall_in          external hold: ID/EX keeps its contents
//   flush             branch taken: squash the instruction entering ID/EX
//   id_*              decoded instruction from ID
//                     id_ctrl = {alu_src, reg_dst, mem_read, mem_write,
//                                reg_write, mem_to_reg, branch}
//   ex_*              registered copy for EX
//                     ex_alu_src selects the ALU operand: 0 = rt_data, 1 = imm
//   hold_if_id        combinational: freeze PC and IF/ID this cycle
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int DW  = 32,
  parameter int RW  = 5,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           stall_in,
  input  logic           flush,
  input  logic           id_valid,
  input  logic [RW-1:0]  id_rs,
  input  logic [RW-1:0]  id_rt,
  input  logic [RW-1:0]  id_rd,
  input  logic           id_uses_rt,
  input  logic [DW-1:0]  id_rs_data,
  input  logic [DW-1:0]  id_rt_data,
  input  logic [DW-1:0]  id_imm,
  input  logic [6:0]     id_ctrl,
  input  logic [OPW-1:0] id_alu_op,
  output logic           ex_valid,
  output logic [RW-1:0]  ex_rs,
  output logic [RW-1:0]  ex_rt,
  output logic [RW-1:0]  ex_rd,
  output logic [DW-1:0]  ex_rs_data,
  output logic [DW-1:0]  ex_rt_data,
  output logic [DW-1:0]  ex_imm,
  output logic           ex_alu_src,
  output logic [5:0]     ex_ctrl_rest,
  output logic [OPW-1:0] ex_alu_op,
  output logic           hold_if_id
);

  typedef struct packed {
    logic           valid;
    logic [RW-1:0]  rs;
    logic [RW-1:0]  rt;
    logic [RW-1:0]  rd;
    logic [DW-1:0]  rs_data;
    logic [DW-1:0]  rt_data;
    logic [DW-1:0]  imm;
    logic [6:0]     ctrl;
    logic [OPW-1:0] alu_op;
  } idex_t;

  idex_t q, d;
  logic  lu;
  logic  ex_mem_read;

  assign ex_mem_read = q.ctrl[4];

  // Load in EX whose destination the ID instruction reads. $0 never stalls.
  assign lu = q.valid & ex_mem_read & (q.rt != '0) & id_valid &
              ((q.rt == id_rs) | (id_uses_rt & (q.rt == id_rt)));

  // A flush squashes the dependent instruction, so no IF/ID hold is needed.
  // Gated by rst_n so an asserted stall_in cannot leak out during reset.
  assign hold_if_id = rst_n & ((lu & ~flush) | stall_in);

  always_comb begin
    d = q;
    if (flush) begin
      d = '0;
    end else if (stall_in) begin
      d = q;
    end else if (lu) begin
      d = '0;
    end else begin
      d.valid   = id_valid;
      d.rs      = id_rs;
      d.rt      = id_rt;
      d.rd      = id_rd;
      d.rs_data = id_rs_data;
      d.rt_data = id_rt_data;
      d.imm     = id_imm;
      d.ctrl    = id_valid ? id_ctrl   : '0;
      d.alu_op  = id_valid ? id_alu_op : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

  assign ex_valid     = q.valid;
  assign ex_rs        = q.rs;
  assign ex_rt        = q.rt;
  assign ex_rd        = q.rd;
  assign ex_rs_data   = q.rs_data;
  assign ex_rt_data   = q.rt_data;
  assign ex_imm       = q.imm;
  assign ex_alu_src   = q.ctrl[6];
  assign ex_ctrl_rest = q.ctrl[5:0];
  assign ex_alu_op    = q.alu_op;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: the driver computes the expected
// hold_if_id and next EX contents from a reference model and queues them;
// a monitor pops and compares against the DUT every cycle.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in, flush, id_valid, id_uses_rt;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [6:0]  id_ctrl;
  logic [3:0]  id_alu_op;
  logic        ex_valid, ex_alu_src, hold_if_id;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [5:0]  ex_ctrl_rest;
  logic [3:0]  ex_alu_op;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .id_alu_op(id_alu_op),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_alu_src(ex_alu_src), .ex_ctrl_rest(ex_ctrl_rest), .ex_alu_op(ex_alu_op),
    .hold_if_id(hold_if_id)
  );

  // Architectural view of the EX-stage instruction.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic [6:0]  ctrl;   // {alu_src, reg_dst, mem_read, mem_write, reg_write, mem_to_reg, branch}
    logic [3:0]  op;
  } ex_t;

  typedef struct {
    logic hold;
    ex_t  nxt;
  } exp_t;

  localparam logic [6:0] C_LW   = 7'b1010110;
  localparam logic [6:0] C_ADD  = 7'b0100100;
  localparam logic [6:0] C_ADDI = 7'b1000100;

  exp_t sb[$];
  ex_t  m;            // reference model of the EX contents
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 0;
  bit   last_hold = 0;

  function automatic ex_t dut_ex();
    ex_t a;
    a.valid = ex_valid; a.rs = ex_rs; a.rt = ex_rt; a.rd = ex_rd;
    a.rsd = ex_rs_data; a.rtd = ex_rt_data; a.imm = ex_imm;
    a.ctrl = {ex_alu_src, ex_ctrl_rest}; a.op = ex_alu_op;
    return a;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One ID presentation per cycle; expected results derived from the rules:
  // a load in EX writing a nonzero register that ID reads costs one bubble,
  // flush always squashes, stall keeps EX unchanged.
  task automatic drive(input logic st, input logic fl, input logic v,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic ur, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [6:0] c, input logic [3:0] op);
    exp_t e;
    bit   reads_load, load_use;
    @(negedge clk);
    stall_in = st; flush = fl; id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rt = ur; id_rs_data = a; id_rt_data = b; id_imm = im;
    id_ctrl = c; id_alu_op = op;
    reads_load = (rs == m.rt) || (ur && rt == m.rt);
    load_use   = m.valid && m.ctrl[4] && m.rt != 0 && v && reads_load;
    e.hold = (load_use && !fl) || st;
    if (fl || (!st && load_use)) e.nxt = '0;
    else if (st)                 e.nxt = m;
    else begin
      e.nxt = '{valid: v, rs: rs, rt: rt, rd: rd, rsd: a, rtd: b, imm: im,
                ctrl: v ? c : 7'd0, op: v ? op : 4'd0};
    end
    sb.push_back(e);
    last_hold = e.hold;
    m = e.nxt;
  endtask

  // Monitor: hold sampled mid-cycle, EX contents just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (mon_en && sb.size() > 0) begin
        e = sb[0];
        chk("hold_if_id", {159'd0, hold_if_id}, {159'd0, e.hold});
        @(posedge clk); #1;
        chk("ex_contents", {{(160-$bits(ex_t)){1'b0}}, dut_ex()},
                           {{(160-$bits(ex_t)){1'b0}}, e.nxt});
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [4:0]  rs, rt;
    logic [6:0]  c;
    logic [31:0] a, b, im;
    logic [3:0]  op;
    logic        v, ur;
    int          wait_cyc;

    // T1: reset with clock running; stall_in high must not reach hold_if_id
    rst_n = 0; stall_in = 1; flush = 0; id_valid = 1; id_rs = 3; id_rt = 4; id_rd = 5;
    id_uses_rt = 1; id_rs_data = 32'h11; id_rt_data = 32'h22; id_imm = 32'h33;
    id_ctrl = C_LW; id_alu_op = 4'h7;
    m = '0;
    repeat (3) @(posedge clk);
    #1 chk("reset_hold", {159'd0, hold_if_id}, 160'd0);
    @(negedge clk); stall_in = 0; id_valid = 0; rst_n = 1;
    #1 chk("reset_ex", {{(160-$bits(ex_t)){1'b0}}, dut_ex()}, 160'd0);
    chk("reset_hold_rel", {159'd0, hold_if_id}, 160'd0);
    mon_en = 1;

    // T2: addi rs=1 rt=2 imm=100
    drive(0, 0, 1, 1, 2, 0, 0, 32'h5, 32'h6, 32'd100, C_ADDI, 4'h2);
    // T3: lw $5 then dependent add; re-presented after one bubble
    drive(0, 0, 1, 1, 5, 0, 0, 32'h10, 32'h0, 32'd8, C_LW, 4'h2);
    drive(0, 0, 1, 5, 6, 7, 1, 32'hA, 32'hB, 32'h0, C_ADD, 4'h2);
    drive(0, 0, 1, 5, 6, 7, 1, 32'hA, 32'hB, 32'h0, C_ADD, 4'h2);
    // T4: load into $0 never stalls; addi reading rt only as destination doesn't either
    drive(0, 0, 1, 1, 0, 0, 0, 32'h1, 32'h0, 32'd4, C_LW, 4'h2);
    drive(0, 0, 1, 0, 0, 3, 1, 32'h0, 32'h0, 32'h0, C_ADD, 4'h2);
    drive(0, 0, 1, 1, 5, 0, 0, 32'h10, 32'h0, 32'd8, C_LW, 4'h2);
    drive(0, 0, 1, 1, 5, 0, 0, 32'h3, 32'h4, 32'd9, C_ADDI, 4'h2);
    // T5: flush beats stall and load-use; then stall alone holds for 3 cycles
    drive(0, 0, 1, 1, 5, 0, 0, 32'h10, 32'h0, 32'd8, C_LW, 4'h2);
    drive(1, 1, 1, 5, 6, 7, 1, 32'hA, 32'hB, 32'h0, C_ADD, 4'h2);
    drive(0, 0, 1, 2, 9, 0, 0, 32'h77, 32'h0, 32'd12, C_LW, 4'h2);
    repeat (3) drive(1, 0, 1, 4'(9), 9, 1, 1, $urandom, $urandom, $urandom, C_ADD, 4'h3);

    // Randomized traffic; a held instruction is re-presented unchanged
    v = 1; rs = 0; rt = 0; ur = 0; a = 0; b = 0; im = 0; c = 0; op = 0;
    for (int i = 0; i < 400; i++) begin
      if (!last_hold || i == 0) begin
        v  = ($urandom_range(0, 7) != 0);
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        ur = $urandom_range(0, 1);
        a = $urandom; b = $urandom; im = $urandom; op = 4'($urandom);
        c = ($urandom_range(0, 2) == 0) ? C_LW : 7'($urandom);
      end
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, v, rs, rt,
            5'($urandom), ur, a, b, im, c, op);
    end

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin @(posedge clk); wait_cyc++; end
    checks++;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    @(negedge clk); mon_en = 0;

    // T6: async reset asserted between edges while a load-use is pending
    stall_in = 0; flush = 0; id_valid = 1; id_rs = 1; id_rt = 5; id_uses_rt = 0;
    id_ctrl = C_LW; id_alu_op = 4'h2;
    @(negedge clk);
    id_rs = 5; id_rt = 6; id_uses_rt = 1; id_ctrl = C_ADD;
    #2 chk("t6_hold_before", {159'd0, hold_if_id}, {159'd0, 1'b1});
    rst_n = 0;
    #1 chk("t6_ex_cleared", {{(160-$bits(ex_t)){1'b0}}, dut_ex()}, 160'd0);
    chk("t6_hold_cleared", {159'd0, hold_if_id}, 160'd0);
    @(negedge clk); rst_n = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
